// File: rtl/cve2_bp_sequencer.sv
// Branch-prediction sequencer: queues outstanding CTI predictions, issues predicted-taken
// and mispredict redirects. Define CVE2_BP_PERF_EN to build the prediction/mispredict counters.
module cve2_bp_sequencer #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     bp_enable_i,
    input  logic                     fetch_valid_i,
    input  logic                     fetch_ready_i,
    input  logic                     fetch_cti_i,
    input  logic                     fetch_compressed_i,
    input  logic [31:0]              fetch_pc_i,
    input  logic                     pred_taken_i,
    input  logic [31:0]              pred_pc_i,
    input  logic                     resolve_valid_i,
    input  logic                     resolve_taken_i,
    input  logic [31:0]              resolve_target_i,
    input  logic                     flush_i,
    output logic                     stall_o,
    output logic                     redirect_o,
    output logic [31:0]              redirect_pc_o,
    output logic                     mispredict_o,
    output logic [31:0]              mispredict_pc_o,
    output logic [CNT_W-1:0]         perf_pred_o,
    output logic [CNT_W-1:0]         perf_mispred_o,
    output logic [1:0]               dbg_state,
    output logic [$clog2(DEPTH):0]   dbg_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e          state;
    logic            entry_taken  [DEPTH];
    logic [31:0]     entry_target [DEPTH];
    logic [31:0]     entry_fall   [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;

    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            mis_now;
    logic            push_taken;
    logic [31:0]     push_fall;
    logic [31:0]     corr_pc;

    assign full       = (count == FULL);
    assign empty      = (count == '0);
    assign stall_o    = full;
    assign dbg_state  = state;
    assign dbg_count  = count;

    assign push_taken = pred_taken_i & bp_enable_i;
    assign push_fall  = fetch_pc_i + (fetch_compressed_i ? 32'd2 : 32'd4);

    // A resolution with nothing outstanding is ignored.
    assign pop     = resolve_valid_i & ~empty;
    assign mis_now = pop & ((entry_taken[rd_ptr] != resolve_taken_i) |
                            (resolve_taken_i & (entry_target[rd_ptr] != resolve_target_i)));
    assign corr_pc = resolve_taken_i ? resolve_target_i : entry_fall[rd_ptr];

    assign push = fetch_valid_i & fetch_ready_i & fetch_cti_i & ~full & ~flush_i &
                  (state != FLUSH) & ~mis_now;

    assign count_next = count + CW'(push) - CW'(pop);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            redirect_o      <= 1'b0;
            redirect_pc_o   <= '0;
            mispredict_o    <= 1'b0;
            mispredict_pc_o <= '0;
        end else if (flush_i) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            redirect_o   <= 1'b0;
            mispredict_o <= 1'b0;
        end else begin
            redirect_o   <= push & push_taken;
            mispredict_o <= mis_now;
            if (push && push_taken) begin
                redirect_pc_o <= pred_pc_i;
            end
            if (mis_now) begin
                mispredict_pc_o <= corr_pc;
                wr_ptr          <= '0;
                rd_ptr          <= '0;
                count           <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count_next;
            end
            case (state)
                IDLE:    if (push) state <= TRACK;
                TRACK: begin
                    if (mis_now)                 state <= FLUSH;
                    else if (count_next == '0)   state <= IDLE;
                end
                FLUSH:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_taken[i]  <= 1'b0;
                entry_target[i] <= '0;
                entry_fall[i]   <= '0;
            end
        end else if (push) begin
            entry_taken[wr_ptr]  <= push_taken;
            entry_target[wr_ptr] <= pred_pc_i;
            entry_fall[wr_ptr]   <= push_fall;
        end
    end

`ifdef CVE2_BP_PERF_EN
    logic [CNT_W-1:0] pred_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    // Saturating counters; a pipeline flush leaves them untouched.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pred_cnt    <= '0;
            mispred_cnt <= '0;
        end else if (!flush_i) begin
            if (pop && (pred_cnt != '1))        pred_cnt    <= pred_cnt + 1'b1;
            if (mis_now && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + 1'b1;
        end
    end

    assign perf_pred_o    = pred_cnt;
    assign perf_mispred_o = mispred_cnt;
`else
    assign perf_pred_o    = '0;
    assign perf_mispred_o = '0;
`endif

endmodule

// File: tb/tb_cve2_bp_sequencer.sv
// Bench for cve2_bp_sequencer: directed scenarios plus random traffic, checked cycle by
// cycle against a queue-based reference model through an expected-response scoreboard.
module tb_cve2_bp_sequencer;

    localparam int DEPTH = 2;
    localparam int CNT_W = 4;
    localparam int PMAX  = (1 << CNT_W) - 1;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              bp_enable;
    logic              fetch_valid;
    logic              fetch_ready;
    logic              fetch_cti;
    logic              fetch_compressed;
    logic [31:0]       fetch_pc;
    logic              pred_taken;
    logic [31:0]       pred_pc;
    logic              resolve_valid;
    logic              resolve_taken;
    logic [31:0]       resolve_target;
    logic              flush;
    logic              stall;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              mispredict;
    logic [31:0]       mispredict_pc;
    logic [CNT_W-1:0]  perf_pred;
    logic [CNT_W-1:0]  perf_mispred;
    logic [1:0]        dbg_state;
    logic [1:0]        dbg_count;

    cve2_bp_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .bp_enable_i        (bp_enable),
        .fetch_valid_i      (fetch_valid),
        .fetch_ready_i      (fetch_ready),
        .fetch_cti_i        (fetch_cti),
        .fetch_compressed_i (fetch_compressed),
        .fetch_pc_i         (fetch_pc),
        .pred_taken_i       (pred_taken),
        .pred_pc_i          (pred_pc),
        .resolve_valid_i    (resolve_valid),
        .resolve_taken_i    (resolve_taken),
        .resolve_target_i   (resolve_target),
        .flush_i            (flush),
        .stall_o            (stall),
        .redirect_o         (redirect),
        .redirect_pc_o      (redirect_pc),
        .mispredict_o       (mispredict),
        .mispredict_pc_o    (mispredict_pc),
        .perf_pred_o        (perf_pred),
        .perf_mispred_o     (perf_mispred),
        .dbg_state          (dbg_state),
        .dbg_count          (dbg_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          taken;
        logic [31:0] target;
        logic [31:0] fall;
    } ent_t;

    typedef struct packed {
        logic             redir;
        logic [31:0]      redir_pc;
        logic             mis;
        logic [31:0]      mis_pc;
        logic             stall;
        logic [CNT_W-1:0] pred;
        logic [CNT_W-1:0] mispred;
        logic [1:0]       state;
        logic [31:0]      count;
    } exp_t;

    ent_t        mq[$];
    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    bit          m_flush = 1'b0;
    logic [31:0] m_redir_pc = '0;
    logic [31:0] m_mis_pc = '0;
    int          m_pred = 0;
    int          m_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CNT_W-1:0] perf_view(input int v);
`ifdef CVE2_BP_PERF_EN
        return CNT_W'(v);
`else
        return '0 & CNT_W'(v);
`endif
    endfunction

    // Reference model: one call per cycle with the inputs about to be sampled.
    task automatic model_step();
        exp_t        e;
        ent_t        h;
        ent_t        n;
        bit          full_now;
        bit          pop;
        bit          mis;
        bit          push;
        logic [31:0] corr;
        full_now = (mq.size() == DEPTH);
        pop  = resolve_valid && (mq.size() > 0);
        mis  = 1'b0;
        corr = '0;
        if (pop) begin
            h    = mq[0];
            mis  = (h.taken != resolve_taken) || (resolve_taken && h.target != resolve_target);
            corr = resolve_taken ? resolve_target : h.fall;
        end
        push = fetch_valid && fetch_ready && fetch_cti && !full_now && !flush && !m_flush && !mis;
        e = '0;
        if (flush) begin
            mq.delete();
            m_flush = 1'b0;
            e.state = ST_IDLE;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                if (m_pred < PMAX) m_pred++;
            end
            if (mis) begin
                mq.delete();
                if (m_mis < PMAX) m_mis++;
                e.mis    = 1'b1;
                m_mis_pc = corr;
            end
            if (push) begin
                n.taken  = pred_taken && bp_enable;
                n.target = pred_pc;
                n.fall   = fetch_pc + (fetch_compressed ? 32'd2 : 32'd4);
                mq.push_back(n);
                if (n.taken) begin
                    e.redir    = 1'b1;
                    m_redir_pc = pred_pc;
                end
            end
            m_flush = mis;
            e.state = mis ? ST_FLUSH : ((mq.size() > 0) ? ST_TRACK : ST_IDLE);
        end
        e.redir_pc = m_redir_pc;
        e.mis_pc   = m_mis_pc;
        e.stall    = (mq.size() == DEPTH);
        e.pred     = perf_view(m_pred);
        e.mispred  = perf_view(m_mis);
        e.count    = mq.size();
        exp_q.push_back(e);
    endtask

    task automatic apply();
        model_step();
        @(negedge clk);
    endtask

    task automatic set_idle();
        bp_enable        = 1'b1;
        fetch_valid      = 1'b0;
        fetch_ready      = 1'b0;
        fetch_cti        = 1'b0;
        fetch_compressed = 1'b0;
        fetch_pc         = '0;
        pred_taken       = 1'b0;
        pred_pc          = '0;
        resolve_valid    = 1'b0;
        resolve_taken    = 1'b0;
        resolve_target   = '0;
        flush            = 1'b0;
    endtask

    task automatic offer(input logic [31:0] pc, input bit comp, input bit taken, input logic [31:0] tgt);
        set_idle();
        fetch_valid      = 1'b1;
        fetch_ready      = 1'b1;
        fetch_cti        = 1'b1;
        fetch_compressed = comp;
        fetch_pc         = pc;
        pred_taken       = taken;
        pred_pc          = tgt;
    endtask

    task automatic resolve(input bit taken, input logic [31:0] tgt);
        set_idle();
        resolve_valid  = 1'b1;
        resolve_taken  = taken;
        resolve_target = tgt;
    endtask

    // Monitor: compares every cycle the DUT presents against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_redirect", 32'(redirect), 32'(e.redir));
                if (e.redir) check("sb_redirect_pc", redirect_pc, e.redir_pc);
                check("sb_mispredict", 32'(mispredict), 32'(e.mis));
                if (e.mis) check("sb_mispredict_pc", mispredict_pc, e.mis_pc);
                check("sb_stall", 32'(stall), 32'(e.stall));
                check("sb_perf_pred", 32'(perf_pred), 32'(e.pred));
                check("sb_perf_mispred", 32'(perf_mispred), 32'(e.mispred));
                check("sb_state", 32'(dbg_state), 32'(e.state));
                check("sb_count", 32'(dbg_count), e.count);
            end
        end
    end

    initial begin
        int r;
        set_idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 0);
        check("rst_redirect", 32'(redirect), 0);
        check("rst_redirect_pc", redirect_pc, 0);
        check("rst_mispredict", 32'(mispredict), 0);
        check("rst_mispredict_pc", mispredict_pc, 0);
        check("rst_perf_pred", 32'(perf_pred), 0);
        check("rst_perf_mispred", 32'(perf_mispred), 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_count", 32'(dbg_count), 0);
        rst_n = 1'b1;

        // Backward branch predicted and resolved taken.
        offer(32'h100, 1'b0, 1'b1, 32'hF0); apply();
        check("bwd_redirect", 32'(redirect), 1);
        check("bwd_redirect_pc", redirect_pc, 32'hF0);
        resolve(1'b1, 32'hF0); apply();
        check("bwd_no_mispredict", 32'(mispredict), 0);
        check("bwd_perf_pred", 32'(perf_pred), 32'(perf_view(1)));

        // Forward compressed branch predicted not-taken, resolved taken.
        offer(32'h200, 1'b1, 1'b0, 32'h240); apply();
        resolve(1'b1, 32'h240); apply();
        check("fwd_mispredict", 32'(mispredict), 1);
        check("fwd_mispredict_pc", mispredict_pc, 32'h240);
        check("fwd_state_flush", 32'(dbg_state), 32'(ST_FLUSH));
        offer(32'h500, 1'b0, 1'b1, 32'h800); apply();
        check("fwd_flush_refuses_push", 32'(dbg_count), 0);
        check("fwd_flush_no_redirect", 32'(redirect), 0);
        check("fwd_mispredict_one_cycle", 32'(mispredict), 0);
        check("fwd_perf_mispred", 32'(perf_mispred), 32'(perf_view(1)));

        // Predicted taken, resolved not-taken: fall through past a 32-bit instruction.
        offer(32'h300, 1'b0, 1'b1, 32'h400); apply();
        resolve(1'b0, 32'h0); apply();
        check("nt_mispredict_pc", mispredict_pc, 32'h304);
        set_idle(); apply();
        check("nt_queue_empty", 32'(dbg_count), 0);

        // Fill the queue, offer a third CTI, then free one slot.
        offer(32'h1000, 1'b0, 1'b0, 32'h2000); apply();
        offer(32'h1004, 1'b0, 1'b0, 32'h2004); apply();
        check("fill_stall", 32'(stall), 1);
        offer(32'h1008, 1'b0, 1'b0, 32'h2008); apply();
        check("fill_third_refused", 32'(dbg_count), 2);
        resolve(1'b0, 32'h0); apply();
        check("fill_stall_cleared", 32'(stall), 0);
        resolve(1'b0, 32'h0); apply();

        // Flush together with a push while a taken redirect is pending.
        offer(32'h600, 1'b0, 1'b1, 32'h700); apply();
        offer(32'h610, 1'b0, 1'b1, 32'h710);
        flush = 1'b1; apply();
        check("flush_no_redirect", 32'(redirect), 0);
        check("flush_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("flush_queue_empty", 32'(dbg_count), 0);

        // Fall-through address wraps past 2^32.
        offer(32'hFFFF_FFFE, 1'b1, 1'b1, 32'h10); apply();
        resolve(1'b0, 32'h0); apply();
        check("wrap_mispredict", 32'(mispredict), 1);
        check("wrap_mispredict_pc", mispredict_pc, 32'h0);

        // Twenty correctly predicted pops saturate the narrow counter.
        for (int i = 0; i < 20; i++) begin
            offer(32'h4000 + 32'(i * 4), 1'b0, 1'b0, 32'h0); apply();
            resolve(1'b0, 32'h0); apply();
        end
        check("sat_perf_pred", 32'(perf_pred), 32'(perf_view(PMAX)));

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            set_idle();
            bp_enable        = ($urandom_range(0, 7) != 0);
            fetch_valid      = ($urandom_range(0, 3) != 0);
            fetch_ready      = ($urandom_range(0, 3) != 0);
            fetch_cti        = ($urandom_range(0, 2) != 0);
            fetch_compressed = $urandom_range(0, 1);
            fetch_pc         = $urandom & 32'hFFFF_FFFE;
            pred_taken       = $urandom_range(0, 1);
            pred_pc          = $urandom & 32'hFFFF_FFFE;
            flush            = ($urandom_range(0, 39) == 0);
            resolve_valid    = !flush && ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 7);
            if (mq.size() > 0 && r <= 4) begin
                resolve_taken  = mq[0].taken;
                resolve_target = mq[0].taken ? mq[0].target : ($urandom & 32'hFFFF_FFFE);
            end else if (mq.size() > 0 && r == 5) begin
                resolve_taken  = 1'b1;
                resolve_target = $urandom & 32'hFFFF_FFFE;
            end else begin
                resolve_taken  = $urandom_range(0, 1);
                resolve_target = $urandom & 32'hFFFF_FFFE;
            end
            apply();
        end

        set_idle();
        apply();
        apply();
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
